// File: rtl/pc_unit_if.sv
// Strobe/field bus between the timing FSM and the program counter stage.
// Outputs (pc, fields, skipped) flow back to the address mux and front panel.
interface pc_unit_if;
    logic        fetch_stb;
    logic        skip_stb;
    logic        skip;
    logic        jmp_stb;
    logic        jms_stb;
    logic [0:11] target;
    logic        cif_stb;
    logic [0:2]  cif_field;
    logic        rmf_stb;
    logic        int_stb;
    logic        load_stb;
    logic        halted;
    logic [0:11] sr;
    logic [0:11] pc;
    logic [0:2]  ifield;
    logic [0:2]  ibfield;
    logic [0:2]  save_field;
    logic        int_inhibit;
    logic        skipped;

    modport master (
        output fetch_stb, skip_stb, skip, jmp_stb, jms_stb, target, cif_stb, cif_field,
               rmf_stb, int_stb, load_stb, halted, sr,
        input  pc, ifield, ibfield, save_field, int_inhibit, skipped
    );

    modport slave (
        input  fetch_stb, skip_stb, skip, jmp_stb, jms_stb, target, cif_stb, cif_field,
               rmf_stb, int_stb, load_stb, halted, sr,
        output pc, ifield, ibfield, save_field, int_inhibit, skipped
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter plus KM8-E instruction-field registers, all outputs registered.
// Define KM8E_EN to build the IF/IB/save-field and interrupt-inhibit logic; otherwise they read 0.
module pc_unit #(
    parameter logic [0:11] RESET_PC = 12'o0200
) (
    input logic         clk100,
    input logic         reset,
    pc_unit_if.slave    bus
);

    logic [0:11] pc_q, pc_d;
    logic        skipped_q, skipped_d;
    logic        do_load, do_int, do_jms, do_jmp, skip_taken;

    // One PC action per cycle; anything below the winner is dropped.
    assign do_load    = bus.load_stb & bus.halted;
    assign do_int     = ~do_load & bus.int_stb;
    assign do_jms     = ~do_load & ~bus.int_stb & bus.jms_stb;
    assign do_jmp     = ~do_load & ~bus.int_stb & ~bus.jms_stb & bus.jmp_stb;
    assign skip_taken = ~do_load & ~bus.int_stb & ~bus.jms_stb & ~bus.jmp_stb
                        & bus.skip_stb & bus.skip;

    always_comb begin
        pc_d      = pc_q;
        skipped_d = 1'b0;
        if (do_load) begin
            pc_d = bus.sr;
        end else if (do_int) begin
            pc_d = 12'o0001;
        end else if (do_jms) begin
            pc_d = bus.target + 12'd1;
        end else if (do_jmp) begin
            pc_d = bus.target;
        end else begin
            pc_d      = pc_q + 12'(bus.fetch_stb) + 12'(skip_taken);
            skipped_d = skip_taken;
        end
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            skipped_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            skipped_q <= skipped_d;
        end
    end

    assign bus.pc      = pc_q;
    assign bus.skipped = skipped_q;

`ifdef KM8E_EN
    logic [0:2] if_q, if_d;
    logic [0:2] ib_q, ib_d;
    logic [0:2] sf_q, sf_d;
    logic       inh_q, inh_d;

    always_comb begin
        if_d  = if_q;
        ib_d  = ib_q;
        sf_d  = sf_q;
        inh_d = inh_q;
        // Field strobes act on IB regardless of the PC action; a transfer
        // of control in the same cycle still clears the inhibit.
        if (bus.cif_stb) begin
            ib_d  = bus.cif_field;
            inh_d = 1'b1;
        end else if (bus.rmf_stb) begin
            ib_d  = sf_q;
            inh_d = 1'b1;
        end
        if (do_load) begin
            if_d = ib_q;
        end else if (do_int) begin
            sf_d  = if_q;
            if_d  = 3'd0;
            if (!bus.cif_stb && !bus.rmf_stb) ib_d = 3'd0;
            inh_d = 1'b0;
        end else if (do_jms || do_jmp) begin
            if_d  = ib_q;
            inh_d = 1'b0;
        end
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            if_q  <= 3'd0;
            ib_q  <= 3'd0;
            sf_q  <= 3'd0;
            inh_q <= 1'b0;
        end else begin
            if_q  <= if_d;
            ib_q  <= ib_d;
            sf_q  <= sf_d;
            inh_q <= inh_d;
        end
    end

    assign bus.ifield      = if_q;
    assign bus.ibfield     = ib_q;
    assign bus.save_field  = sf_q;
    assign bus.int_inhibit = inh_q;
`else
    logic unused_field_inputs;
    assign unused_field_inputs = ^{bus.cif_stb, bus.rmf_stb, bus.cif_field};

    assign bus.ifield      = 3'd0;
    assign bus.ibfield     = 3'd0;
    assign bus.save_field  = 3'd0;
    assign bus.int_inhibit = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; field expectations collapse to 0 when KM8E_EN is undefined.
module tb_pc_unit;

`ifdef KM8E_EN
    localparam bit Km = 1'b1;
`else
    localparam bit Km = 1'b0;
`endif

    logic clk100 = 1'b0;
    logic reset  = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    pc_unit_if bus ();

    pc_unit #(.RESET_PC(12'o0200)) dut (
        .clk100 (clk100),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #5 clk100 = ~clk100;

    function automatic logic [31:0] fx(input logic [31:0] v);
        return Km ? v : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0o expected %0o", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.fetch_stb = 1'b0;
        bus.skip_stb  = 1'b0;
        bus.jmp_stb   = 1'b0;
        bus.jms_stb   = 1'b0;
        bus.cif_stb   = 1'b0;
        bus.rmf_stb   = 1'b0;
        bus.int_stb   = 1'b0;
        bus.load_stb  = 1'b0;
    endtask

    // Apply whatever strobes are set for exactly one rising edge, then sample.
    task automatic cycle();
        @(posedge clk100);
        #1;
        clear_inputs();
    endtask

    task automatic load_pc(input logic [0:11] v);
        bus.halted   = 1'b1;
        bus.sr       = v;
        bus.load_stb = 1'b1;
        cycle();
        bus.halted   = 1'b0;
    endtask

    initial begin
        clear_inputs();
        bus.skip      = 1'b0;
        bus.target    = '0;
        bus.cif_field = '0;
        bus.halted    = 1'b0;
        bus.sr        = '0;
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;

        check("reset_pc", bus.pc, 12'o0200);
        check("reset_if", bus.ifield, 0);
        check("reset_ib", bus.ibfield, 0);
        check("reset_sf", bus.save_field, 0);
        check("reset_inh", bus.int_inhibit, 0);
        check("reset_skipped", bus.skipped, 0);

        for (int i = 1; i <= 3; i++) begin
            bus.fetch_stb = 1'b1;
            cycle();
            check("fetch_pc", bus.pc, 12'o0200 + i);
            check("fetch_skipped", bus.skipped, 0);
        end

        // skip level alone must not move the PC
        bus.skip = 1'b1;
        cycle();
        check("skip_no_stb_pc", bus.pc, 12'o0203);

        load_pc(12'o7777);
        check("load_7777", bus.pc, 12'o7777);
        bus.fetch_stb = 1'b1; bus.skip_stb = 1'b1; bus.skip = 1'b1;
        cycle();
        check("fetch_skip_wrap_pc", bus.pc, 12'o0001);
        check("fetch_skip_skipped", bus.skipped, 1);
        check("wrap_if", bus.ifield, 0);
        cycle();
        check("skipped_pulse_end", bus.skipped, 0);

        load_pc(12'o7777);
        bus.fetch_stb = 1'b1; bus.skip_stb = 1'b1; bus.skip = 1'b0;
        cycle();
        check("fetch_noskip_pc", bus.pc, 12'o0000);
        check("fetch_noskip_skipped", bus.skipped, 0);

        bus.skip_stb = 1'b1; bus.skip = 1'b1;
        cycle();
        check("skip_only_pc", bus.pc, 12'o0001);
        check("skip_only_skipped", bus.skipped, 1);
        bus.skip = 1'b0;

        bus.cif_stb = 1'b1; bus.cif_field = 3'd3;
        cycle();
        check("cif_ib", bus.ibfield, fx(3));
        check("cif_inh", bus.int_inhibit, fx(1));
        check("cif_if", bus.ifield, 0);
        bus.jmp_stb = 1'b1; bus.target = 12'o0400;
        cycle();
        check("jmp_pc", bus.pc, 12'o0400);
        check("jmp_if", bus.ifield, fx(3));
        check("jmp_inh", bus.int_inhibit, 0);

        // cif together with jmp: IF takes old IB, inhibit cleared
        bus.cif_stb = 1'b1; bus.cif_field = 3'd5; bus.jmp_stb = 1'b1; bus.target = 12'o1234;
        cycle();
        check("cifjmp_pc", bus.pc, 12'o1234);
        check("cifjmp_if", bus.ifield, fx(3));
        check("cifjmp_ib", bus.ibfield, fx(5));
        check("cifjmp_inh", bus.int_inhibit, 0);
        bus.jmp_stb = 1'b1; bus.target = 12'o1234;
        cycle();
        check("if5_if", bus.ifield, fx(5));

        bus.int_stb = 1'b1;
        cycle();
        check("int_pc", bus.pc, 12'o0001);
        check("int_if", bus.ifield, 0);
        check("int_ib", bus.ibfield, 0);
        check("int_sf", bus.save_field, fx(5));
        bus.rmf_stb = 1'b1;
        cycle();
        check("rmf_ib", bus.ibfield, fx(5));
        check("rmf_inh", bus.int_inhibit, fx(1));
        bus.jms_stb = 1'b1; bus.target = 12'o2000;
        cycle();
        check("jms_pc", bus.pc, 12'o2001);
        check("jms_if", bus.ifield, fx(5));
        check("jms_inh", bus.int_inhibit, 0);

        bus.jms_stb = 1'b1; bus.target = 12'o7777;
        cycle();
        check("jms_wrap_pc", bus.pc, 12'o0000);

        bus.sr = 12'o4567; bus.halted = 1'b0; bus.load_stb = 1'b1;
        cycle();
        check("load_running_pc", bus.pc, 12'o0000);
        bus.sr = 12'o4567; bus.halted = 1'b1; bus.load_stb = 1'b1;
        cycle();
        check("load_halted_pc", bus.pc, 12'o4567);
        bus.sr = 12'o1111; bus.load_stb = 1'b1; bus.int_stb = 1'b1;
        cycle();
        bus.halted = 1'b0;
        check("load_int_pc", bus.pc, 12'o1111);
        check("load_int_sf", bus.save_field, fx(5));
        check("load_int_if", bus.ifield, fx(5));

        bus.jmp_stb = 1'b1; bus.target = 12'o3000; bus.skip_stb = 1'b1; bus.skip = 1'b1;
        bus.fetch_stb = 1'b1;
        cycle();
        check("jmp_skip_pc", bus.pc, 12'o3000);
        check("jmp_skip_skipped", bus.skipped, 0);
        bus.skip = 1'b0;

        reset = 1'b1; bus.jms_stb = 1'b1; bus.target = 12'o5000;
        cycle();
        reset = 1'b0;
        check("rst_jms_pc", bus.pc, 12'o0200);
        check("rst_jms_if", bus.ifield, 0);
        check("rst_jms_ib", bus.ibfield, 0);
        check("rst_jms_sf", bus.save_field, 0);
        check("rst_jms_inh", bus.int_inhibit, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
